memoria_dados_bytes: RTL and testbench

MEMORIA_DADOS_BYTES -- requirements
Module: memoria_dados_bytes

---
 rtl/memoria_dados_bytes.sv | 184 ++++++++++++++++++
 tb/tb_memoria_dados_bytes.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/memoria_dados_bytes.sv
// Byte-addressable 32-bit data memory with LATENCIA wait states and a one-cycle Pronto pulse.
// Define MEMORIA_ERRO_ALINHAMENTO_EN to flag misaligned accesses instead of truncating the address.
module memoria_dados_bytes #(
  parameter int LARGURA_ENDERECO = 10,
  parameter int LATENCIA         = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Requisicao,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Endereco,
  input  logic [1:0]  Tamanho,
  input  logic        SemSinal,
  input  logic [31:0] DadosEscrita,
  output logic [31:0] DadosLidos,
  output logic        Pronto,
  output logic        Ocupado,
  output logic        ErroAlinhamento
);
  // state   | meaning
  // OCIOSO  | idle, samples Requisicao
  // ESPERA  | wait states, counter runs down to terminal count 1
  // CONCLUI | access done, Pronto high for one cycle
  typedef enum logic [1:0] {OCIOSO = 2'd0, ESPERA = 2'd1, CONCLUI = 2'd2} estado_t;

  localparam int         PROFUNDIDADE = 2 ** LARGURA_ENDERECO;
  localparam int         AW           = LARGURA_ENDERECO + 2;
  localparam logic [2:0] CARGA        = 3'(LATENCIA);

  estado_t estado, proximo;
  logic [2:0] contador, contador_prox;
  logic aceita, executa;

  logic          cap_escrita, cap_sem;
  logic [AW-1:0] cap_end;
  logic [1:0]    cap_tam;
  logic [31:0]   cap_dados;

  logic          op_escrita, op_sem;
  logic [AW-1:0] op_end;
  logic [1:0]    op_tam;
  logic [31:0]   op_dados;

  logic [31:0] mem [PROFUNDIDADE];
  logic [LARGURA_ENDERECO-1:0] indice;
  logic [1:0]  lane;
  logic        desalinhado, eh_palavra, eh_meia;
  logic [3:0]  hab_byte;
  logic [31:0] dados_lane, palavra, leitura;
  logic [15:0] meia;
  logic [7:0]  octeto;

  logic unused_endereco;
  assign unused_endereco = ^Endereco[31:AW];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado      <= OCIOSO;
      contador    <= '0;
      DadosLidos  <= '0;
      cap_escrita <= 1'b0;
      cap_sem     <= 1'b0;
      cap_end     <= '0;
      cap_tam     <= '0;
      cap_dados   <= '0;
    end else begin
      estado   <= proximo;
      contador <= contador_prox;
      if (aceita) begin
        cap_escrita <= MemWrite;
        cap_sem     <= SemSinal;
        cap_end     <= Endereco[AW-1:0];
        cap_tam     <= Tamanho;
        cap_dados   <= DadosEscrita;
      end
      if (executa && !op_escrita)
        DadosLidos <= desalinhado ? '0 : leitura;
    end
  end

  always_comb begin
    proximo       = estado;
    contador_prox = contador;
    aceita        = 1'b0;
    executa       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (Requisicao && (MemRead || MemWrite)) begin
          aceita = 1'b1;
          if (LATENCIA == 0) begin
            executa = 1'b1;
            proximo = CONCLUI;
          end else begin
            proximo       = ESPERA;
            contador_prox = CARGA;
          end
        end
      end
      ESPERA: begin
        if (contador == 3'd1) begin
          executa       = 1'b1;
          proximo       = CONCLUI;
          contador_prox = '0;
        end else begin
          contador_prox = contador - 3'd1;
        end
      end
      CONCLUI: proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  // Zero wait states execute on the accept edge, before the capture registers load.
  assign op_escrita = (estado == OCIOSO) ? MemWrite     : cap_escrita;
  assign op_sem     = (estado == OCIOSO) ? SemSinal     : cap_sem;
  assign op_end     = (estado == OCIOSO) ? Endereco[AW-1:0] : cap_end;
  assign op_tam     = (estado == OCIOSO) ? Tamanho      : cap_tam;
  assign op_dados   = (estado == OCIOSO) ? DadosEscrita : cap_dados;

  assign eh_palavra = op_tam[1];
  assign eh_meia    = (op_tam == 2'b01);
  assign indice     = op_end[AW-1:2];

`ifdef MEMORIA_ERRO_ALINHAMENTO_EN
  assign desalinhado = eh_palavra ? (op_end[1:0] != 2'b00) : (eh_meia & op_end[0]);
  assign lane        = op_end[1:0];
`else
  assign desalinhado = 1'b0;
  assign lane        = eh_palavra ? 2'b00 : (eh_meia ? {op_end[1], 1'b0} : op_end[1:0]);
`endif

  always_comb begin
    hab_byte   = 4'b0000;
    dados_lane = op_dados;
    if (eh_palavra) begin
      hab_byte = 4'b1111;
    end else if (eh_meia) begin
      hab_byte   = lane[1] ? 4'b1100 : 4'b0011;
      dados_lane = {2{op_dados[15:0]}};
    end else begin
      hab_byte   = 4'b0001 << lane;
      dados_lane = {4{op_dados[7:0]}};
    end
  end

  assign palavra = mem[indice];

  always_comb begin
    meia = lane[1] ? palavra[31:16] : palavra[15:0];
    case (lane)
      2'd0:    octeto = palavra[7:0];
      2'd1:    octeto = palavra[15:8];
      2'd2:    octeto = palavra[23:16];
      default: octeto = palavra[31:24];
    endcase
    if (eh_palavra)   leitura = palavra;
    else if (eh_meia) leitura = {{16{meia[15] & ~op_sem}}, meia};
    else              leitura = {{24{octeto[7] & ~op_sem}}, octeto};
  end

  // No reset on the array: contents survive Reset, and a reset edge cancels a due write.
  always_ff @(posedge Clock) begin
    if (!Reset && executa && op_escrita && !desalinhado) begin
      for (int k = 0; k < 4; k++)
        if (hab_byte[k]) mem[indice][8*k +: 8] <= dados_lane[8*k +: 8];
    end
  end

`ifdef MEMORIA_ERRO_ALINHAMENTO_EN
  logic erro_q;
  always_ff @(posedge Clock) begin
    if (Reset) erro_q <= 1'b0;
    else       erro_q <= executa & desalinhado;
  end
  assign ErroAlinhamento = erro_q;
`else
  assign ErroAlinhamento = 1'b0;
`endif

  assign Pronto  = (estado == CONCLUI);
  assign Ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_memoria_dados_bytes.sv
// Directed bench for memoria_dados_bytes: three instances with LATENCIA 1, 0 and 7.
// Expectations follow MEMORIA_ERRO_ALINHAMENTO_EN when the bench is built with it defined.
module tb_memoria_dados_bytes;
  logic Clock = 1'b0;
  logic Reset;
  logic MemRead, MemWrite, SemSinal;
  logic [31:0] Endereco, DadosEscrita;
  logic [1:0]  Tamanho;
  logic req0, req1, req7;
  logic [31:0] dl0, dl1, dl7;
  logic pr0, pr1, pr7, oc0, oc1, oc7, er0, er1, er7;

  always #5 Clock = ~Clock;

`ifdef MEMORIA_ERRO_ALINHAMENTO_EN
  localparam logic MAC = 1'b1;
`else
  localparam logic MAC = 1'b0;
`endif

  memoria_dados_bytes #(.LARGURA_ENDERECO(10), .LATENCIA(1)) u1 (
    .Clock(Clock), .Reset(Reset), .Requisicao(req1), .MemRead(MemRead), .MemWrite(MemWrite),
    .Endereco(Endereco), .Tamanho(Tamanho), .SemSinal(SemSinal), .DadosEscrita(DadosEscrita),
    .DadosLidos(dl1), .Pronto(pr1), .Ocupado(oc1), .ErroAlinhamento(er1));
  memoria_dados_bytes #(.LARGURA_ENDERECO(10), .LATENCIA(0)) u0 (
    .Clock(Clock), .Reset(Reset), .Requisicao(req0), .MemRead(MemRead), .MemWrite(MemWrite),
    .Endereco(Endereco), .Tamanho(Tamanho), .SemSinal(SemSinal), .DadosEscrita(DadosEscrita),
    .DadosLidos(dl0), .Pronto(pr0), .Ocupado(oc0), .ErroAlinhamento(er0));
  memoria_dados_bytes #(.LARGURA_ENDERECO(10), .LATENCIA(7)) u7 (
    .Clock(Clock), .Reset(Reset), .Requisicao(req7), .MemRead(MemRead), .MemWrite(MemWrite),
    .Endereco(Endereco), .Tamanho(Tamanho), .SemSinal(SemSinal), .DadosEscrita(DadosEscrita),
    .DadosLidos(dl7), .Pronto(pr7), .Ocupado(oc7), .ErroAlinhamento(er7));

  int verificacoes = 0;
  int falhas = 0;

  typedef struct {
    logic        escreve;
    logic [31:0] ender;
    logic [1:0]  tam;
    logic        sem;
    logic [31:0] dado;
    logic [31:0] esp_lido;
    logic        esp_erro;
  } vetor_t;

  vetor_t tab[$];

  task automatic verifica(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    verificacoes++;
    if (obtido !== esperado) begin
      falhas++;
      $display("FAIL %s: got %h, expected %h", nome, obtido, esperado);
    end
  endtask

  task automatic poe_req(input int sel, input logic v);
    if (sel == 0) req0 = v;
    else if (sel == 7) req7 = v;
    else req1 = v;
  endtask

  task automatic acesso(input int sel, input logic escreve, input logic [31:0] ender,
                        input logic [1:0] tam, input logic sem, input logic [31:0] dado,
                        output int ciclos, output logic [31:0] lido, output logic erro);
    logic p;
    MemWrite = escreve; MemRead = ~escreve; Endereco = ender;
    Tamanho = tam; SemSinal = sem; DadosEscrita = dado;
    poe_req(sel, 1'b1);
    ciclos = -1; lido = 'x; erro = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clock);
      poe_req(sel, 1'b0);
      // scramble the bus: the access must use the captured operands
      MemWrite = ~escreve; MemRead = escreve; Endereco = ~ender;
      Tamanho = ~tam; SemSinal = ~sem; DadosEscrita = ~dado;
      p = (sel == 0) ? pr0 : (sel == 7) ? pr7 : pr1;
      if (p) begin
        ciclos = n;
        lido = (sel == 0) ? dl0 : (sel == 7) ? dl7 : dl1;
        erro = (sel == 0) ? er0 : (sel == 7) ? er7 : er1;
        break;
      end
    end
    @(negedge Clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int ciclos, primeiro, pulsos;
    logic [31:0] lido, ultimo_lido, esp;
    logic erro;

    Reset = 1'b1; req0 = 0; req1 = 0; req7 = 0;
    MemRead = 0; MemWrite = 0; Endereco = 0; Tamanho = 0; SemSinal = 0; DadosEscrita = 0;
    repeat (3) @(negedge Clock);
    verifica("reset Pronto",  32'(pr1), 32'd0);
    verifica("reset Ocupado", 32'(oc1), 32'd0);
    verifica("reset Erro",    32'(er1), 32'd0);
    verifica("reset DadosLidos", dl1, 32'd0);
    verifica("reset DadosLidos L7", dl7, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    tab.push_back(vetor_t'{1'b1, 32'h10,   2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h10,   2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h20,   2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h22,   2'd0, 1'b0, 32'h123456AA, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h20,   2'd2, 1'b0, 32'h0, 32'h11AA3344, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h22,   2'd0, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h22,   2'd0, 1'b1, 32'h0, 32'h000000AA, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h20,   2'd1, 1'b0, 32'h0, 32'h00003344, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h22,   2'd1, 1'b0, 32'h0, 32'h000011AA, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h24,   2'd2, 1'b0, 32'h00000000, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h26,   2'd1, 1'b0, 32'hABCD8001, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h24,   2'd2, 1'b0, 32'h0, 32'h80010000, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h26,   2'd1, 1'b0, 32'h0, 32'hFFFF8001, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h26,   2'd1, 1'b1, 32'h0, 32'h00008001, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h21,   2'd0, 1'b0, 32'h0000007F, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h20,   2'd2, 1'b0, 32'h0, 32'h11AA7F44, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h21,   2'd0, 1'b0, 32'h0, 32'h0000007F, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h23,   2'd0, 1'b0, 32'h0, 32'h00000011, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h1004, 2'd2, 1'b0, 32'hCAFEBABE, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h0004, 2'd2, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h10,   2'd3, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h40,   2'd2, 1'b0, 32'h01020304, 32'h0, 1'b0});
    tab.push_back(vetor_t'{1'b1, 32'h42,   2'd2, 1'b0, 32'hA5A5A5A5, 32'h0, MAC});
    tab.push_back(vetor_t'{1'b0, 32'h40,   2'd2, 1'b0, 32'h0, MAC ? 32'h01020304 : 32'hA5A5A5A5, 1'b0});
    tab.push_back(vetor_t'{1'b0, 32'h42,   2'd2, 1'b0, 32'h0, MAC ? 32'h00000000 : 32'hA5A5A5A5, MAC});
    tab.push_back(vetor_t'{1'b0, 32'h21,   2'd1, 1'b1, 32'h0, MAC ? 32'h00000000 : 32'h00007F44, MAC});

    ultimo_lido = 32'h0;
    foreach (tab[i]) begin
      acesso(1, tab[i].escreve, tab[i].ender, tab[i].tam, tab[i].sem, tab[i].dado, ciclos, lido, erro);
      esp = tab[i].escreve ? ultimo_lido : tab[i].esp_lido;
      ultimo_lido = esp;
      verifica($sformatf("vec%0d latency", i), 32'(ciclos), 32'd2);
      verifica($sformatf("vec%0d DadosLidos", i), lido, esp);
      verifica($sformatf("vec%0d Erro", i), 32'(erro), 32'(tab[i].esp_erro));
    end

    // reset while a write sits in ESPERA: the write is dropped, memory survives
    acesso(1, 1'b1, 32'h40, 2'd2, 1'b0, 32'h600DCAFE, ciclos, lido, erro);
    MemWrite = 1; MemRead = 0; Endereco = 32'h40; Tamanho = 2'd2; SemSinal = 0;
    DadosEscrita = 32'h00000055; req1 = 1;
    @(negedge Clock);
    req1 = 0;
    verifica("espera Ocupado", 32'(oc1), 32'd1);
    verifica("espera Pronto", 32'(pr1), 32'd0);
    Reset = 1;
    @(negedge Clock);
    verifica("post-reset Pronto", 32'(pr1), 32'd0);
    verifica("post-reset Ocupado", 32'(oc1), 32'd0);
    verifica("post-reset Erro", 32'(er1), 32'd0);
    verifica("post-reset DadosLidos", dl1, 32'd0);
    Reset = 0;
    @(negedge Clock);
    verifica("discarded Pronto", 32'(pr1), 32'd0);
    acesso(1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, ciclos, lido, erro);
    verifica("after-reset latency", 32'(ciclos), 32'd2);
    verifica("after-reset word 0x40", lido, 32'h600DCAFE);

    // zero wait states
    acesso(0, 1'b1, 32'h30, 2'd2, 1'b0, 32'h0A0B0C0D, ciclos, lido, erro);
    verifica("L0 write latency", 32'(ciclos), 32'd1);
    acesso(0, 1'b0, 32'h30, 2'd2, 1'b0, 32'h0, ciclos, lido, erro);
    verifica("L0 read latency", 32'(ciclos), 32'd1);
    verifica("L0 read data", lido, 32'h0A0B0C0D);

    // seven wait states with request pulses while busy
    MemWrite = 1; MemRead = 0; Endereco = 32'h80; Tamanho = 2'd2; SemSinal = 0;
    DadosEscrita = 32'h12345678; req7 = 1;
    primeiro = -1; pulsos = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge Clock);
      if (pr7) begin
        pulsos++;
        if (primeiro < 0) primeiro = n;
      end
      if (n == 2 || n == 4 || n == 6) begin
        req7 = 1; Endereco = 32'h80; DadosEscrita = 32'h0BADF00D;
      end else begin
        req7 = 0; DadosEscrita = 32'hFFFFFFFF;
      end
    end
    verifica("L7 first Pronto", 32'(primeiro), 32'd8);
    verifica("L7 Pronto count", 32'(pulsos), 32'd1);
    acesso(7, 1'b0, 32'h80, 2'd2, 1'b0, 32'h0, ciclos, lido, erro);
    verifica("L7 read latency", 32'(ciclos), 32'd8);
    verifica("L7 read data", lido, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", verificacoes, falhas);
    $finish;
  end
endmodule
